// File: rtl/seven_seg_capture.sv
// Receive-side monitor for a multiplexed, active-low seven-segment bus.
// Waits for each digit slot to settle, then decodes and checks it.
module seven_seg_capture #(
    parameter int NUM_SEGMENTS   = 4,
    parameter int CLK_PER        = 10,
    parameter int REFR_RATE      = 1000,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4 * (1000000000 / (CLK_PER * REFR_RATE))
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SEGMENTS-1:0]      anode,
    input  logic [6:0]                   cathode,
    output logic [NUM_SEGMENTS-1:0][3:0] decoded,
    output logic [NUM_SEGMENTS-1:0]      digit_valid,
    output logic                         capture,
    output logic                         frame_done,
    output logic                         err_pattern,
    output logic                         err_anode,
    output logic                         stalled
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    // Returns {legal, value}; the cathode is inverted to the lit-segment set first.
    function automatic logic [4:0] decode_glyph(input logic [6:0] cath);
        logic [6:0] seg;
        seg = ~cath;
        case (seg)
            7'h3F:   decode_glyph = {1'b1, 4'h0};
            7'h06:   decode_glyph = {1'b1, 4'h1};
            7'h5B:   decode_glyph = {1'b1, 4'h2};
            7'h4F:   decode_glyph = {1'b1, 4'h3};
            7'h66:   decode_glyph = {1'b1, 4'h4};
            7'h6D:   decode_glyph = {1'b1, 4'h5};
            7'h7D:   decode_glyph = {1'b1, 4'h6};
            7'h07:   decode_glyph = {1'b1, 4'h7};
            7'h7F:   decode_glyph = {1'b1, 4'h8};
            7'h6F:   decode_glyph = {1'b1, 4'h9};
            7'h77:   decode_glyph = {1'b1, 4'hA};
            7'h7C:   decode_glyph = {1'b1, 4'hB};
            7'h39:   decode_glyph = {1'b1, 4'hC};
            7'h5E:   decode_glyph = {1'b1, 4'hD};
            7'h79:   decode_glyph = {1'b1, 4'hE};
            7'h71:   decode_glyph = {1'b1, 4'hF};
            default: decode_glyph = 5'h00;
        endcase
    endfunction

    logic [NUM_SEGMENTS-1:0] anode_p0, anode_p1, anode_p2;
    logic [6:0]              cathode_p0, cathode_p1, cathode_p2;
    logic [CNT_W-1:0]        cnt;
    logic [TO_W-1:0]         tcnt;
    logic [NUM_SEGMENTS-1:0] frame_mask;

    logic [NUM_SEGMENTS-1:0] low;
    logic [NUM_SEGMENTS-1:0] mask_next;
    logic                    changed, stable_evt, one_hot, multi_low, cap_evt, anode_evt;
    logic [4:0]              glyph;

    assign low        = ~anode_p1;
    assign multi_low  = (low & (low - NUM_SEGMENTS'(1))) != '0;
    assign one_hot    = (low != '0) && !multi_low;
    assign changed    = (anode_p1 != anode_p2) || (cathode_p1 != cathode_p2);
    assign stable_evt = (cnt == CNT_FIRE) && !changed;
    assign cap_evt    = stable_evt && one_hot;
    assign anode_evt  = stable_evt && multi_low;
    assign glyph      = decode_glyph(cathode_p1);
    assign mask_next  = frame_mask | low;
    assign stalled    = (tcnt >= TO_MAX);

    // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_p0   <= '1;
            anode_p1   <= '1;
            anode_p2   <= '1;
            cathode_p0 <= '1;
            cathode_p1 <= '1;
            cathode_p2 <= '1;
        end else begin
            anode_p0   <= anode;
            anode_p1   <= anode_p0;
            anode_p2   <= anode_p1;
            cathode_p0 <= cathode;
            cathode_p1 <= cathode_p0;
            cathode_p2 <= cathode_p1;
        end
    end

    // Stability window, classification and capture state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            tcnt        <= '0;
            frame_mask  <= '0;
            decoded     <= '0;
            digit_valid <= '0;
            capture     <= 1'b0;
            frame_done  <= 1'b0;
            err_pattern <= 1'b0;
            err_anode   <= 1'b0;
        end else begin
            if (changed)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            capture     <= cap_evt;
            err_pattern <= cap_evt && !glyph[4];
            err_anode   <= anode_evt;
            frame_done  <= cap_evt && (mask_next == '1);

            if (cap_evt)
                tcnt <= '0;
            else if (tcnt != TO_MAX)
                tcnt <= tcnt + 1'b1;

            if (cap_evt)
                frame_mask <= (mask_next == '1) ? '0 : mask_next;

            // Illegal glyphs keep the last good value but drop the valid flag.
            for (int k = 0; k < NUM_SEGMENTS; k++) begin
                if (cap_evt && low[k]) begin
                    if (glyph[4])
                        decoded[k] <= glyph[3:0];
                    digit_valid[k] <= glyph[4];
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture with hand-computed expectations.
// REFR_RATE is raised so the stall timeout is 4*(1e9/(10*100000)) = 4000 cycles.
module tb_seven_seg_capture;

    localparam int NSEG = 4;
    localparam int TMO  = 4000;

    logic                 clk;
    logic                 rst_n;
    logic [NSEG-1:0]      anode;
    logic [6:0]           cathode;
    logic [NSEG-1:0][3:0] decoded;
    logic [NSEG-1:0]      digit_valid;
    logic                 capture, frame_done, err_pattern, err_anode, stalled;

    int checks = 0;
    int errors = 0;
    int cap_n = 0, fd_n = 0, ep_n = 0, ea_n = 0;

    seven_seg_capture #(
        .NUM_SEGMENTS (NSEG),
        .CLK_PER      (10),
        .REFR_RATE    (100000),
        .STABLE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .anode      (anode),
        .cathode    (cathode),
        .decoded    (decoded),
        .digit_valid(digit_valid),
        .capture    (capture),
        .frame_done (frame_done),
        .err_pattern(err_pattern),
        .err_anode  (err_anode),
        .stalled    (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (capture)     cap_n++;
        if (frame_done)  fd_n++;
        if (err_pattern) ep_n++;
        if (err_anode)   ea_n++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b1;
        anode   = 4'hF;
        cathode = 7'h7F;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (decoded !== 16'h0) begin errors++; $display("FAIL reset_decoded got %h want 0000", decoded); end
        checks++; if (digit_valid !== 4'h0) begin errors++; $display("FAIL reset_valid got %b want 0000", digit_valid); end
        checks++; if ({capture, frame_done, err_pattern, err_anode} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b want 0000", {capture, frame_done, err_pattern, err_anode}); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled got %b want 0", stalled); end
        step(3);
        rst_n = 1'b1;
        step(10);
        checks++; if (cap_n !== 0 || ea_n !== 0) begin errors++; $display("FAIL reset_release_spurious got cap=%0d ea=%0d want 0 0", cap_n, ea_n); end
    endtask

    task automatic test_single_digit;
        int c0;
        c0 = cap_n;
        anode   = 4'b1110;
        cathode = 7'b0100100;
        step(6);
        checks++; if (capture !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", capture); end
        step(1);
        checks++; if (capture !== 1'b1) begin errors++; $display("FAIL single_capture got %b want 1", capture); end
        checks++; if (decoded[0] !== 4'h2) begin errors++; $display("FAIL single_decoded got %h want 2", decoded[0]); end
        checks++; if (digit_valid !== 4'b0001) begin errors++; $display("FAIL single_valid got %b want 0001", digit_valid); end
        step(20);
        checks++; if (cap_n - c0 !== 1) begin errors++; $display("FAIL single_pulse_count got %0d want 1", cap_n - c0); end
    endtask

    task automatic test_frame_scan;
        logic [3:0] an_tab [4];
        logic [6:0] ca_tab [4];
        int f0;
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        ca_tab = '{7'b1111001, 7'b0001000, 7'b0000000, 7'b0001110};
        f0 = fd_n;
        for (int i = 0; i < 4; i++) begin
            anode   = an_tab[i];
            cathode = ca_tab[i];
            step(7);
            checks++; if (capture !== 1'b1) begin errors++; $display("FAIL scan_capture digit %0d got %b want 1", i, capture); end
            checks++; if (frame_done !== (i == 3)) begin errors++; $display("FAIL scan_frame_done digit %0d got %b want %b", i, frame_done, (i == 3)); end
            step(13);
        end
        checks++; if (decoded !== 16'hF8A1) begin errors++; $display("FAIL scan_decoded got %h want F8A1", decoded); end
        checks++; if (digit_valid !== 4'hF) begin errors++; $display("FAIL scan_valid got %b want 1111", digit_valid); end
        checks++; if (fd_n - f0 !== 1) begin errors++; $display("FAIL scan_frame_count got %0d want 1", fd_n - f0); end
    endtask

    task automatic test_illegal;
        anode   = 4'b1101;
        cathode = 7'b1110111;
        step(7);
        checks++; if ({capture, err_pattern} !== 2'b11) begin errors++; $display("FAIL illegal_pulses got %b want 11", {capture, err_pattern}); end
        checks++; if (digit_valid !== 4'b1101) begin errors++; $display("FAIL illegal_valid got %b want 1101", digit_valid); end
        checks++; if (decoded[1] !== 4'hA) begin errors++; $display("FAIL illegal_held got %h want A", decoded[1]); end
        step(10);
    endtask

    task automatic test_err_anode;
        int c0, a0;
        c0 = cap_n;
        a0 = ea_n;
        anode   = 4'b1100;
        cathode = 7'b0100100;
        step(7);
        checks++; if ({err_anode, capture} !== 2'b10) begin errors++; $display("FAIL anode_err got %b want 10", {err_anode, capture}); end
        step(3);
        checks++; if (ea_n - a0 !== 1 || cap_n - c0 !== 0) begin errors++; $display("FAIL anode_counts got ea=%0d cap=%0d want 1 0", ea_n - a0, cap_n - c0); end
        a0 = ea_n;
        anode = 4'b1110;
        step(3);
        anode = 4'b1100;
        step(10);
        checks++; if (cap_n - c0 !== 0) begin errors++; $display("FAIL glitch_capture got %0d want 0", cap_n - c0); end
        checks++; if (ea_n - a0 !== 1) begin errors++; $display("FAIL glitch_anode got %0d want 1", ea_n - a0); end
    endtask

    task automatic test_stall;
        anode   = 4'b1011;
        cathode = 7'b0000000;
        step(7);
        checks++; if (capture !== 1'b1) begin errors++; $display("FAIL stall_seed_capture got %b want 1", capture); end
        anode = 4'b1111;
        step(TMO - 1);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL stall_early got %b want 0", stalled); end
        step(1);
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_rise got %b want 1", stalled); end
        anode   = 4'b1110;
        cathode = 7'b0110000;
        step(6);
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_hold got %b want 1", stalled); end
        step(1);
        checks++; if ({capture, stalled} !== 2'b10) begin errors++; $display("FAIL stall_clear got %b want 10", {capture, stalled}); end
        checks++; if (decoded[0] !== 4'h3) begin errors++; $display("FAIL stall_decoded got %h want 3", decoded[0]); end
        step(10);
    endtask

    task automatic test_reset_mid;
        int c0;
        anode   = 4'b1011;
        cathode = 7'b0010010;
        step(3);
        rst_n = 1'b0;
        #1;
        checks++; if (decoded !== 16'h0 || digit_valid !== 4'h0) begin errors++; $display("FAIL mid_reset_state got %h/%b want 0000/0000", decoded, digit_valid); end
        checks++; if ({capture, frame_done, err_pattern, err_anode, stalled} !== 5'b0) begin errors++; $display("FAIL mid_reset_flags got %b want 00000", {capture, frame_done, err_pattern, err_anode, stalled}); end
        step(2);
        c0 = cap_n;
        rst_n = 1'b1;
        step(6);
        checks++; if (cap_n - c0 !== 0 || capture !== 1'b0) begin errors++; $display("FAIL mid_reset_early got %0d want 0", cap_n - c0); end
        step(1);
        checks++; if (capture !== 1'b1) begin errors++; $display("FAIL mid_reset_capture got %b want 1", capture); end
        checks++; if (decoded !== 16'h0500 || digit_valid !== 4'b0100) begin errors++; $display("FAIL mid_reset_decoded got %h/%b want 0500/0100", decoded, digit_valid); end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_frame_scan();
        test_illegal();
        test_err_anode();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
